// File: rtl/pc_unit_ctl.sv
// pc_unit_ctl: program-counter unit for the IF stage.
//   Each cycle it selects the next fetch address from one of four paths:
//   sequential, branch, jump or jump-register. It also handles fetch stall,
//   exception entry to a fixed vector with EPC capture, and ERET return.
//
// Ports
//   CLK       in   clock, rising edge
//   RST       in   asynchronous active-high reset
//   Stall     in   hold PC and state this cycle
//   PCSel     in   next-PC select: 00 seq, 01 branch, 10 jump, 11 jr
//   Offset    in   signed branch offset, in words
//   Target    in   J-type instruction index
//   RegAddr   in   jump-register target
//   Exc       in   exception request (one-cycle pulse)
//   Eret      in   return-from-exception request (one-cycle pulse)
//   PC        out  current fetch address (registered)
//   NPC       out  PC + STEP (combinational)
//   EPC       out  saved exception PC (registered)
//   InHandler out  high while in the exception state (registered)
//
// Optional feature macro: ADDR_CHECK_EN
//   When defined, a jr to a misaligned address raises an address-error
//   exception. Two outputs are added: BadAddr (the faulting address) and
//   AdEL (a one-cycle pulse).
//   When undefined, jr clears the two low address bits instead.
module pc_unit_ctl #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_4180),
  parameter int unsigned     STEP      = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Stall,
  input  logic [1:0]       PCSel,
  input  logic [15:0]      Offset,
  input  logic [25:0]      Target,
  input  logic [WIDTH-1:0] RegAddr,
  input  logic             Exc,
  input  logic             Eret,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] NPC,
  output logic [WIDTH-1:0] EPC,
`ifdef ADDR_CHECK_EN
  output logic [WIDTH-1:0] BadAddr,
  output logic             AdEL,
`endif
  output logic             InHandler
);

  typedef enum logic [0:0] {StRun, StExc} state_e;
  state_e state_q;

  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] jmp_pc;
  logic [WIDTH-1:0] path_pc;
  logic             eret_take;
  logic             ad_err;
  logic             take_exc;

  assign NPC = PC + WIDTH'(STEP);

  // Sign-extend the word offset and convert it to bytes.
  assign br_off = WIDTH'({{(WIDTH-18){Offset[15]}}, Offset, 2'b00});

  // Only the low 28 bits are replaced; the upper region comes from NPC.
  always_comb begin
    jmp_pc       = NPC;
    jmp_pc[27:0] = {Target, 2'b00};
  end

  // Eret only acts in EXC, and a simultaneous Exc pre-empts it.
  assign eret_take = Eret && (state_q == StExc) && !Exc;

`ifdef ADDR_CHECK_EN
  assign ad_err = (PCSel == 2'b11) && (RegAddr[1:0] != 2'b00) && !Stall && !eret_take;
`else
  assign ad_err = 1'b0;
  logic unused_regaddr_lsbs;
  assign unused_regaddr_lsbs = ^RegAddr[1:0];
`endif

  assign take_exc = Exc || ad_err;

  always_comb begin
    path_pc = NPC;
    unique case (PCSel)
      2'b00: path_pc = NPC;
      2'b01: path_pc = NPC + br_off;
      2'b10: path_pc = jmp_pc;
      2'b11: path_pc = {RegAddr[WIDTH-1:2], 2'b00};
      default: path_pc = NPC;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StRun;
      PC        <= RESET_VEC;
      EPC       <= '0;
      InHandler <= 1'b0;
`ifdef ADDR_CHECK_EN
      BadAddr   <= '0;
      AdEL      <= 1'b0;
`endif
    end else begin
`ifdef ADDR_CHECK_EN
      AdEL <= 1'b0;
      // Captured even when an external Exc takes the exception this cycle.
      if (ad_err) begin
        BadAddr <= RegAddr;
        AdEL    <= 1'b1;
      end
`endif
      if (take_exc) begin
        // A nested exception keeps the original return address.
        if (state_q == StRun) EPC <= PC;
        PC        <= EXC_VEC;
        state_q   <= StExc;
        InHandler <= 1'b1;
      end else if (eret_take) begin
        PC        <= EPC;
        state_q   <= StRun;
        InHandler <= 1'b0;
      end else if (!Stall) begin
        PC <= path_pc;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit_ctl.sv
module tb_pc_unit_ctl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Stall = 1'b0;
  logic [1:0]  PCSel = 2'b00;
  logic [15:0] Offset = '0;
  logic [25:0] Target = '0;
  logic [31:0] RegAddr = '0;
  logic        Exc = 1'b0;
  logic        Eret = 1'b0;
  logic [31:0] PC, NPC, EPC;
  logic        InHandler;
`ifdef ADDR_CHECK_EN
  logic [31:0] BadAddr;
  logic        AdEL;
`endif

  pc_unit_ctl dut (
    .CLK(CLK), .RST(RST), .Stall(Stall), .PCSel(PCSel), .Offset(Offset),
    .Target(Target), .RegAddr(RegAddr), .Exc(Exc), .Eret(Eret),
    .PC(PC), .NPC(NPC), .EPC(EPC),
`ifdef ADDR_CHECK_EN
    .BadAddr(BadAddr), .AdEL(AdEL),
`endif
    .InHandler(InHandler)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        inh;
    logic [31:0] bad;
    logic        adel;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;

  // Monitor: one expected record per rising edge, checked just after it.
  always @(posedge CLK) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      n_vec++;
      if (PC !== mon_e.pc) begin
        n_miss++;
        $display("FAIL %s pc: got %h want %h", mon_e.name, PC, mon_e.pc);
      end
      if (NPC !== mon_e.pc + 32'd4) begin
        n_miss++;
        $display("FAIL %s npc: got %h want %h", mon_e.name, NPC, mon_e.pc + 32'd4);
      end
      if (EPC !== mon_e.epc) begin
        n_miss++;
        $display("FAIL %s epc: got %h want %h", mon_e.name, EPC, mon_e.epc);
      end
      if (InHandler !== mon_e.inh) begin
        n_miss++;
        $display("FAIL %s inhandler: got %b want %b", mon_e.name, InHandler, mon_e.inh);
      end
`ifdef ADDR_CHECK_EN
      if (BadAddr !== mon_e.bad) begin
        n_miss++;
        $display("FAIL %s badaddr: got %h want %h", mon_e.name, BadAddr, mon_e.bad);
      end
      if (AdEL !== mon_e.adel) begin
        n_miss++;
        $display("FAIL %s adel: got %b want %b", mon_e.name, AdEL, mon_e.adel);
      end
`endif
    end
  end

  // Drive one cycle of stimulus on the falling edge and queue the result
  // expected after the next rising edge.
  task automatic step(input string name, input logic rst, input logic stall,
                      input logic [1:0] sel, input logic [15:0] off,
                      input logic [25:0] tgt, input logic [31:0] ra,
                      input logic exc, input logic eret,
                      input logic [31:0] pc, input logic [31:0] epc,
                      input logic inh, input logic [31:0] bad, input logic adel);
    exp_t e;
    @(negedge CLK);
    RST = rst; Stall = stall; PCSel = sel; Offset = off; Target = tgt;
    RegAddr = ra; Exc = exc; Eret = eret;
    e.name = name; e.pc = pc; e.epc = epc; e.inh = inh; e.bad = bad; e.adel = adel;
    q.push_back(e);
  endtask

  initial begin
    //    name        rst stl sel    off       tgt         regaddr       exc eret  pc            epc           inh bad           adel
    step("reset",     1, 0, 2'b00, 16'h0000, 26'h0,      32'h0,        0, 0, 32'h0000_3000, 32'h0,        0, 32'h0,        0);
    step("seq1",      0, 0, 2'b00, 16'h0000, 26'h0,      32'h0,        0, 0, 32'h0000_3004, 32'h0,        0, 32'h0,        0);
    step("seq2",      0, 0, 2'b00, 16'h0000, 26'h0,      32'h0,        0, 0, 32'h0000_3008, 32'h0,        0, 32'h0,        0);
    step("seq3",      0, 0, 2'b00, 16'h0000, 26'h0,      32'h0,        0, 0, 32'h0000_300C, 32'h0,        0, 32'h0,        0);
    step("jr3010a",   0, 0, 2'b11, 16'h0000, 26'h0,      32'h0000_3010, 0, 0, 32'h0000_3010, 32'h0,       0, 32'h0,        0);
    step("br_neg",    0, 0, 2'b01, 16'hFFFC, 26'h0,      32'h0,        0, 0, 32'h0000_3004, 32'h0,        0, 32'h0,        0);
    step("jr3010b",   0, 0, 2'b11, 16'h0000, 26'h0,      32'h0000_3010, 0, 0, 32'h0000_3010, 32'h0,       0, 32'h0,        0);
    step("br_pos",    0, 0, 2'b01, 16'h0003, 26'h0,      32'h0,        0, 0, 32'h0000_3020, 32'h0,        0, 32'h0,        0);
    step("jr3000",    0, 0, 2'b11, 16'h0000, 26'h0,      32'h0000_3000, 0, 0, 32'h0000_3000, 32'h0,       0, 32'h0,        0);
    step("jump",      0, 0, 2'b10, 16'h0000, 26'h0000C40, 32'h0,       0, 0, 32'h0000_3100, 32'h0,        0, 32'h0,        0);
    step("jr5000",    0, 0, 2'b11, 16'h0000, 26'h0,      32'h0000_5000, 0, 0, 32'h0000_5000, 32'h0,       0, 32'h0,        0);
    step("stall1",    0, 1, 2'b01, 16'h0003, 26'h0,      32'h0,        0, 0, 32'h0000_5000, 32'h0,        0, 32'h0,        0);
    step("stall2",    0, 1, 2'b01, 16'h0003, 26'h0,      32'h0,        0, 0, 32'h0000_5000, 32'h0,        0, 32'h0,        0);
    step("stall3",    0, 1, 2'b01, 16'h0003, 26'h0,      32'h0,        0, 0, 32'h0000_5000, 32'h0,        0, 32'h0,        0);
    step("jr3008",    0, 0, 2'b11, 16'h0000, 26'h0,      32'h0000_3008, 0, 0, 32'h0000_3008, 32'h0,       0, 32'h0,        0);
    step("stall_exc", 0, 1, 2'b01, 16'h0003, 26'h0,      32'h0,        1, 0, 32'h0000_4180, 32'h0000_3008, 1, 32'h0,       0);
    step("nested",    0, 0, 2'b00, 16'h0000, 26'h0,      32'h0,        1, 0, 32'h0000_4180, 32'h0000_3008, 1, 32'h0,       0);
    step("eret",      0, 0, 2'b00, 16'h0000, 26'h0,      32'h0,        0, 1, 32'h0000_3008, 32'h0000_3008, 0, 32'h0,       0);
    step("eret_run",  0, 0, 2'b00, 16'h0000, 26'h0,      32'h0,        0, 1, 32'h0000_300C, 32'h0000_3008, 0, 32'h0,       0);
    step("exc2",      0, 0, 2'b00, 16'h0000, 26'h0,      32'h0,        1, 0, 32'h0000_4180, 32'h0000_300C, 1, 32'h0,       0);
    step("exc_eret",  0, 0, 2'b00, 16'h0000, 26'h0,      32'h0,        1, 1, 32'h0000_4180, 32'h0000_300C, 1, 32'h0,       0);
    step("eret_stl",  0, 1, 2'b01, 16'h0003, 26'h0,      32'h0,        0, 1, 32'h0000_300C, 32'h0000_300C, 0, 32'h0,       0);
    step("jr_top",    0, 0, 2'b11, 16'h0000, 26'h0,      32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 32'h0000_300C, 0, 32'h0,      0);
    step("wrap",      0, 0, 2'b00, 16'h0000, 26'h0,      32'h0,        0, 0, 32'h0000_0000, 32'h0000_300C, 0, 32'h0,       0);
    step("rst_exc",   1, 0, 2'b00, 16'h0000, 26'h0,      32'h0,        1, 0, 32'h0000_3000, 32'h0,        0, 32'h0,        0);
    step("post_rst",  0, 0, 2'b00, 16'h0000, 26'h0,      32'h0,        0, 0, 32'h0000_3004, 32'h0,        0, 32'h0,        0);
    step("jr3000b",   0, 0, 2'b11, 16'h0000, 26'h0,      32'h0000_3000, 0, 0, 32'h0000_3000, 32'h0,       0, 32'h0,        0);
`ifdef ADDR_CHECK_EN
    step("jr_mis",    0, 0, 2'b11, 16'h0000, 26'h0,      32'h0000_5002, 0, 0, 32'h0000_4180, 32'h0000_3000, 1, 32'h0000_5002, 1);
    step("after_mis", 0, 0, 2'b00, 16'h0000, 26'h0,      32'h0,        0, 0, 32'h0000_4184, 32'h0000_3000, 1, 32'h0000_5002, 0);
`else
    step("jr_mis",    0, 0, 2'b11, 16'h0000, 26'h0,      32'h0000_5002, 0, 0, 32'h0000_5000, 32'h0,       0, 32'h0,        0);
    step("after_mis", 0, 0, 2'b00, 16'h0000, 26'h0,      32'h0,        0, 0, 32'h0000_5004, 32'h0,        0, 32'h0,        0);
`endif
    @(negedge CLK);
    Stall = 1'b0; PCSel = 2'b00; Exc = 1'b0; Eret = 1'b0;
    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge CLK);
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
